// File: rtl/regfile.sv
`timescale 1ns/1ps
// regfile
// General-purpose register file for the five-stage pipeline. It accepts one
// write per cycle from the writeback bus and serves two combinational read
// ports to ID. A write is forwarded to a read of the same address in the same
// cycle. It also keeps a count of committed writes and runs a handshaked dump
// engine that streams every register out for trace and debug.
//
// Ports
//   i_clk                 clock; all state changes on the rising edge
//   i_rst_n               asynchronous reset, active-low
//   i_we/i_waddr/i_wdata  write port, driven by the writeback stage
//   i_re1/i_raddr1        read port 1 enable and address
//   o_rdata1              read port 1 data (combinational)
//   i_re2/i_raddr2        read port 2 enable and address
//   o_rdata2              read port 2 data (combinational)
//   i_dump_start          single-cycle request to stream out all registers
//   o_dump_valid          o_dump_addr/o_dump_data carry a beat
//   i_dump_ready          sink accepts the current beat
//   o_dump_addr           index of the register being emitted
//   o_dump_data           committed value of that register (no bypass)
//   o_dump_busy           dump in progress
//   o_dump_done           one-cycle pulse after the last beat is accepted
//   o_wr_count            count of committed writes, wraps at 16 bits
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re1,
  input  logic [ADDR_W-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata1,
  input  logic              i_re2,
  input  logic [ADDR_W-1:0] i_raddr2,
  output logic [DATA_W-1:0] o_rdata2,
  input  logic              i_dump_start,
  output logic              o_dump_valid,
  input  logic              i_dump_ready,
  output logic [ADDR_W-1:0] o_dump_addr,
  output logic [DATA_W-1:0] o_dump_data,
  output logic              o_dump_busy,
  output logic              o_dump_done,
  output logic [15:0]       o_wr_count
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    S_IDLE,
    S_EMIT
  } state_t;

  logic [DATA_W-1:0] r_mem [NREG];
  logic [15:0]       r_wr_count;
  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_idx;
  logic [ADDR_W-1:0] w_idx_next;
  logic              r_done;
  logic              w_done_next;
  logic              w_commit;
  logic              w_emit;

  // Writes to register 0 are dropped entirely, so they never reach the
  // array and never count as committed.
  assign w_commit = i_we && (i_waddr != '0);
  assign w_emit   = (r_state == S_EMIT);

  // Storage array and committed-write counter. Entry 0 is never written, so
  // it stays at its reset value of zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_count <= '0;
    end else if (w_commit) begin
      r_mem[i_waddr] <= i_wdata;
      r_wr_count     <= r_wr_count + 16'd1;
    end
  end

  // Read ports: reset, disabled port and address 0 all force zero; otherwise
  // a same-cycle write to the read address is forwarded ahead of the array.
  assign o_rdata1 = (!i_rst_n || !i_re1 || (i_raddr1 == '0)) ? '0 :
                    (i_we && (i_waddr == i_raddr1))          ? i_wdata :
                                                               r_mem[i_raddr1];
  assign o_rdata2 = (!i_rst_n || !i_re2 || (i_raddr2 == '0)) ? '0 :
                    (i_we && (i_waddr == i_raddr2))          ? i_wdata :
                                                               r_mem[i_raddr2];

  // Dump engine state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_done  <= w_done_next;
    end
  end

  // Dump engine next state. A start request while emitting is simply ignored.
  // The index returns to zero after the last beat so the idle address reads 0.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dump_start) begin
          w_state_next = S_EMIT;
          w_idx_next   = '0;
        end
      end
      S_EMIT: begin
        if (i_dump_ready) begin
          if (r_idx == LAST_IDX) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
            w_done_next  = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  // Dump data reads the array directly, so a stalled beat follows later writes
  // to its register but never sees the write bypass.
  assign o_dump_valid = w_emit;
  assign o_dump_busy  = w_emit;
  assign o_dump_addr  = r_idx;
  assign o_dump_data  = (w_emit && (r_idx != '0)) ? r_mem[r_idx] : '0;
  assign o_dump_done  = r_done;
  assign o_wr_count   = r_wr_count;

endmodule

// File: tb/tb_regfile.sv
`timescale 1ns/1ps
// tb_regfile
// Self-checking bench for regfile: a fixed vector table for the write/bypass
// and read-enable rules, randomized traffic against a behavioural model, and
// hand-written sequences for the dump engine, counter wrap and reset cases.
module tb_regfile;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic          dumpStart;
  logic          dumpValid;
  logic          dumpReady;
  logic [AW-1:0] dumpAddr;
  logic [DW-1:0] dumpData;
  logic          dumpBusy;
  logic          dumpDone;
  logic [15:0]   wrCount;

  regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_we         (we),
    .i_waddr      (waddr),
    .i_wdata      (wdata),
    .i_re1        (re1),
    .i_raddr1     (raddr1),
    .o_rdata1     (rdata1),
    .i_re2        (re2),
    .i_raddr2     (raddr2),
    .o_rdata2     (rdata2),
    .i_dump_start (dumpStart),
    .o_dump_valid (dumpValid),
    .i_dump_ready (dumpReady),
    .o_dump_addr  (dumpAddr),
    .o_dump_data  (dumpData),
    .o_dump_busy  (dumpBusy),
    .o_dump_done  (dumpDone),
    .o_wr_count   (wrCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model: plain array of register contents, write counter and
  // a simple "dump in progress / next index expected" view of the dump.
  logic [DW-1:0] mMem [NREG];
  logic [15:0]   mCnt;
  logic          mBusy;
  int            mIdx;
  logic          mDone;
  int            beatCount;
  int            doneCount;
  logic [DW-1:0] beatData [NREG];

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          re1;
    logic [AW-1:0] ra1;
    logic          re2;
    logic [AW-1:0] ra2;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
    logic [15:0]   ec;
  } vec_t;

  vec_t vecs [9];

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [AW-1:0] wa,
                               input logic [DW-1:0] wd, input logic r1,
                               input logic [AW-1:0] a1, input logic r2,
                               input logic [AW-1:0] a2);
    we = w; waddr = wa; wdata = wd;
    re1 = r1; raddr1 = a1; re2 = r2; raddr2 = a2;
  endtask

  function automatic logic [DW-1:0] modelRead(input logic re, input logic [AW-1:0] a);
    if (!rst_n) return '0;
    if (!re) return '0;
    if (a == 0) return '0;
    if (we && waddr == a) return wdata;
    return mMem[a];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < NREG; i++) mMem[i] = '0;
    mCnt = '0; mBusy = 1'b0; mIdx = 0; mDone = 1'b0;
  endtask

  // One clock: check any beat offered before the edge, advance the model on
  // the edge, then check the dump status just after it.
  task automatic tick();
    logic beat;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    beat = dumpValid && dumpReady && rst_n;
    a = dumpAddr;
    d = dumpData;
    if (beat) begin
      checkOutput("dump_addr", {27'd0, a}, mIdx);
      checkOutput("dump_data", d, mMem[mIdx]);
      beatCount++;
      beatData[a] = d;
    end
    @(posedge clk);
    mDone = 1'b0;
    if (rst_n) begin
      if (mBusy) begin
        if (dumpReady) begin
          if (mIdx == NREG - 1) begin
            mBusy = 1'b0; mDone = 1'b1; mIdx = 0;
          end else begin
            mIdx++;
          end
        end
      end else if (dumpStart) begin
        mBusy = 1'b1; mIdx = 0;
      end
      if (we && waddr != 0) begin
        mMem[waddr] = wdata;
        mCnt = mCnt + 16'd1;
      end
    end
    #1;
    checkOutput("dump_busy", {31'd0, dumpBusy}, {31'd0, mBusy});
    checkOutput("dump_valid", {31'd0, dumpValid}, {31'd0, mBusy});
    checkOutput("dump_done", {31'd0, dumpDone}, {31'd0, mDone});
    if (dumpDone) doneCount++;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #1;
    clearModel();
    checkOutput("rst_dump_valid", {31'd0, dumpValid}, 0);
    checkOutput("rst_dump_busy", {31'd0, dumpBusy}, 0);
    checkOutput("rst_dump_done", {31'd0, dumpDone}, 0);
    checkOutput("rst_dump_addr", {27'd0, dumpAddr}, 0);
    checkOutput("rst_dump_data", dumpData, 0);
    checkOutput("rst_wr_count", {16'd0, wrCount}, 0);
    checkOutput("rst_rdata1", rdata1, 0);
    checkOutput("rst_rdata2", rdata2, 0);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    clearModel();
    dumpStart = 1'b0;
    dumpReady = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd5, 1'b1, 5'd5);
    doReset();
    tick();
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    rst_n = 1'b1;
    tick();

    // Write/bypass, address-0 and read-enable vectors from the reset state.
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0,        16'd0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b1, 5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
    vecs[2] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0,  1'b1, 5'd5,  32'h0,        32'hDEADBEEF, 16'd1};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd5,  32'h0,        32'h0,        16'd1};
    vecs[4] = '{1'b1, 5'd7,  32'h000000A5, 1'b1, 5'd7,  1'b1, 5'd5,  32'h000000A5, 32'hDEADBEEF, 16'd1};
    vecs[5] = '{1'b1, 5'd7,  32'h0000005A, 1'b1, 5'd7,  1'b1, 5'd7,  32'h0000005A, 32'h0000005A, 16'd2};
    vecs[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  32'h0000005A, 32'h0,        16'd3};
    vecs[7] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 1'b1, 5'd30, 32'hFFFFFFFF, 32'h0,        16'd3};
    vecs[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd5,  32'hFFFFFFFF, 32'hDEADBEEF, 16'd4};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].re1, vecs[i].ra1,
                    vecs[i].re2, vecs[i].ra2);
      #1;
      checkOutput($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].e1);
      checkOutput($sformatf("vec%0d_rdata2", i), rdata2, vecs[i].e2);
      checkOutput($sformatf("vec%0d_wr_count", i), {16'd0, wrCount}, {16'd0, vecs[i].ec});
      tick();
    end

    // Reset asserted mid-run clears everything.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    doReset();
    tick();
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < NREG; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, a[AW-1:0], 1'b1, a[AW-1:0]);
      #1;
      checkOutput($sformatf("post_rst_rd1_%0d", a), rdata1, 0);
      checkOutput($sformatf("post_rst_rd2_%0d", a), rdata2, 0);
    end
    checkOutput("post_rst_wr_count", {16'd0, wrCount}, 0);
    checkOutput("post_rst_dump_valid", {31'd0, dumpValid}, 0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, NREG - 1));
      applyStimulus(1'($urandom_range(0, 1)), wa, $urandom(),
                    1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, NREG - 1)),
                    1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 1) != 0) ? wa : AW'($urandom_range(0, NREG - 1)));
      #1;
      checkOutput("rand_rdata1", rdata1, modelRead(re1, raddr1));
      checkOutput("rand_rdata2", rdata2, modelRead(re2, raddr2));
      checkOutput("rand_wr_count", {16'd0, wrCount}, {16'd0, mCnt});
      tick();
    end

    // Dump with random backpressure.
    for (int i = 0; i < NREG; i++) begin
      applyStimulus(1'b1, i[AW-1:0], 32'h100 + i, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    beatCount = 0; doneCount = 0;
    dumpStart = 1'b1;
    dumpReady = 1'($urandom_range(0, 1));
    tick();
    dumpStart = 1'b0;
    checkOutput("first_beat_valid", {31'd0, dumpValid}, 1);
    n = 0;
    while (doneCount == 0 && n < 1000) begin
      dumpReady = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    dumpReady = 1'b1;
    tick(); tick(); tick();
    checkOutput("bp_beat_count", beatCount, NREG);
    checkOutput("bp_done_count", doneCount, 1);
    for (int i = 0; i < NREG; i++) begin
      checkOutput($sformatf("bp_beat%0d", i), beatData[i], (i == 0) ? 0 : 32'h100 + i);
    end

    // Write during a stalled dump, plus an ignored mid-dump start.
    beatCount = 0; doneCount = 0;
    dumpStart = 1'b1;
    dumpReady = 1'b1;
    tick();
    dumpStart = 1'b0;
    n = 0;
    while (dumpAddr != 5'd3 && n < 50) begin
      tick();
      n++;
    end
    dumpReady = 1'b0;
    checkOutput("stall_at_idx3", {27'd0, dumpAddr}, 3);
    applyStimulus(1'b1, 5'd3, 32'hAA, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b1, 5'd1, 32'hBB, 1'b0, 5'd0, 1'b0, 5'd0);
    dumpStart = 1'b1;
    tick();
    dumpStart = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("stall_addr_held", {27'd0, dumpAddr}, 3);
    checkOutput("stall_data_tracks", dumpData, 32'hAA);
    dumpReady = 1'b1;
    n = 0;
    while (doneCount == 0 && n < 100) begin
      tick();
      n++;
    end
    tick(); tick(); tick();
    checkOutput("wdd_beat_count", beatCount, NREG);
    checkOutput("wdd_done_count", doneCount, 1);
    checkOutput("wdd_beat3", beatData[3], 32'hAA);
    checkOutput("wdd_beat1", beatData[1], 32'h101);
    checkOutput("wdd_no_restart", {31'd0, dumpBusy}, 0);

    // Counter wrap after 65536 committed writes from reset.
    doReset();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      applyStimulus(1'b1, AW'($urandom_range(1, NREG - 1)), $urandom(),
                    1'b0, 5'd0, 1'b0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    checkOutput("wr_count_wrap", {16'd0, wrCount}, 0);

    // Reset in the middle of a dump aborts it without a done pulse.
    doneCount = 0;
    dumpStart = 1'b1;
    dumpReady = 1'b1;
    tick();
    dumpStart = 1'b0;
    n = 0;
    while (dumpAddr != 5'd10 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("reach_idx10", {27'd0, dumpAddr}, 10);
    checkOutput("busy_before_rst", {31'd0, dumpBusy}, 1);
    doReset();
    checkOutput("busy_after_rst", {31'd0, dumpBusy}, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    checkOutput("no_done_after_abort", doneCount, 0);
    checkOutput("idle_after_abort", {31'd0, dumpBusy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
